// File: rtl/iq_demod_ctrl_if.sv
// Bus between the IQ demodulation chain and its sequencing controller.
// The controller is the slave; the chain/test environment is the master.
interface iq_demod_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              enable;
  logic              ADC_rdy;
  logic              valid_I;
  logic              valid_Q;
  logic signed [4:0] I_filt;
  logic signed [4:0] Q_filt;
  logic              demod_en;
  logic              filt_flush;
  logic              lo_phase_rst;
  logic              demod_iq_valid;
  logic signed [4:0] I_BB;
  logic signed [4:0] Q_BB;
  logic [2:0]        state;
  logic              sync_err;
  logic              starve_err;
  logic [CNT_W-1:0]  sample_cnt;

  modport master (
    output enable, ADC_rdy, valid_I, valid_Q, I_filt, Q_filt,
    input  demod_en, filt_flush, lo_phase_rst, demod_iq_valid, I_BB, Q_BB,
           state, sync_err, starve_err, sample_cnt
  );

  modport slave (
    input  enable, ADC_rdy, valid_I, valid_Q, I_filt, Q_filt,
    output demod_en, filt_flush, lo_phase_rst, demod_iq_valid, I_BB, Q_BB,
           state, sync_err, starve_err, sample_cnt
  );
endinterface

// File: rtl/iq_demod_ctrl.sv
// Sequencing controller for the IQ demodulation chain: flush, filter settling,
// aligned I/Q delivery to the CORDIC, plus desync and ADC starvation monitoring.
module iq_demod_ctrl #(
  parameter int SETTLE_SAMPLES = 20,
  parameter int TIMEOUT        = 256,
  parameter int CNT_W          = 16
) (
  input  logic          clk,
  input  logic          resetn,
  iq_demod_ctrl_if.slave bus
);

  localparam int SW = $clog2(SETTLE_SAMPLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sync_err_q, sync_err_d;
  logic              starve_err_q, starve_err_d;
  logic              flush_q, valid_q;
  logic signed [4:0] i_bb_q, q_bb_q;

  logic cv_s, desync_s, active_s, starve_s, settle_done_s;
  logic deliver_s, flush_entry_s, demod_en_s;

  assign cv_s          = bus.valid_I & bus.valid_Q;
  assign desync_s      = bus.valid_I ^ bus.valid_Q;
  assign active_s      = (state_q == ST_SETTLE) || (state_q == ST_RUN);
  // The TIMEOUT-th consecutive idle cycle is the one that trips the watchdog.
  assign starve_s      = (state_q == ST_RUN) && !bus.ADC_rdy &&
                         (wd_q == WW'(TIMEOUT - 1));
  assign settle_done_s = (state_q == ST_SETTLE) && cv_s &&
                         (settle_q == SW'(SETTLE_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_FLUSH;
        else            state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (!bus.enable) state_d = ST_IDLE;
        else             state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!bus.enable)        state_d = ST_IDLE;
        else if (desync_s)      state_d = ST_ERROR;
        else if (settle_done_s) state_d = ST_RUN;
        else                    state_d = ST_SETTLE;
      end
      ST_RUN: begin
        if (!bus.enable)               state_d = ST_IDLE;
        else if (desync_s || starve_s) state_d = ST_ERROR;
        else                           state_d = ST_RUN;
      end
      ST_ERROR: begin
        if (!bus.enable) state_d = ST_IDLE;
        else             state_d = ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    demod_en_s    = bus.ADC_rdy & active_s;
    flush_entry_s = (state_d == ST_FLUSH);
    deliver_s     = (state_q == ST_RUN) && bus.enable && cv_s && !starve_s;
  end

  always_comb begin
    settle_d     = settle_q;
    wd_d         = wd_q;
    cnt_d        = cnt_q;
    sync_err_d   = sync_err_q;
    starve_err_d = starve_err_q;
    if (flush_entry_s) begin
      settle_d     = '0;
      wd_d         = '0;
      cnt_d        = '0;
      sync_err_d   = 1'b0;
      starve_err_d = 1'b0;
    end else begin
      if ((state_q == ST_SETTLE) && bus.enable && cv_s) settle_d = settle_q + SW'(1);
      else                                              settle_d = settle_q;
      if (state_q != ST_RUN)                  wd_d = wd_q;
      else if (bus.ADC_rdy)                   wd_d = '0;
      else if (wd_q != WW'(TIMEOUT))          wd_d = wd_q + WW'(1);
      else                                    wd_d = wd_q;
      if (deliver_s && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      else                                       cnt_d = cnt_q;
      sync_err_d   = sync_err_q | (active_s & bus.enable & desync_s);
      starve_err_d = starve_err_q | (bus.enable & starve_s);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      settle_q     <= '0;
      wd_q         <= '0;
      cnt_q        <= '0;
      sync_err_q   <= 1'b0;
      starve_err_q <= 1'b0;
      flush_q      <= 1'b0;
      valid_q      <= 1'b0;
      i_bb_q       <= 5'sd0;
      q_bb_q       <= 5'sd0;
    end else begin
      settle_q     <= settle_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      sync_err_q   <= sync_err_d;
      starve_err_q <= starve_err_d;
      flush_q      <= flush_entry_s;
      valid_q      <= deliver_s;
      if (deliver_s) begin
        i_bb_q <= bus.I_filt;
        q_bb_q <= bus.Q_filt;
      end else begin
        i_bb_q <= i_bb_q;
        q_bb_q <= q_bb_q;
      end
    end
  end

  assign bus.demod_en       = demod_en_s;
  assign bus.filt_flush     = flush_q;
  assign bus.lo_phase_rst   = flush_q;
  assign bus.demod_iq_valid = valid_q;
  assign bus.I_BB           = i_bb_q;
  assign bus.Q_BB           = q_bb_q;
  assign bus.state          = state_q;
  assign bus.sync_err       = sync_err_q;
  assign bus.starve_err     = starve_err_q;
  assign bus.sample_cnt     = cnt_q;

endmodule

// File: tb/tb_iq_demod_ctrl.sv
// Directed bench for iq_demod_ctrl; a second CNT_W=4 instance shares the
// stimulus to observe sample counter saturation.
module tb_iq_demod_ctrl;

  logic       clk = 1'b0;
  logic       t_resetn = 1'b1;
  logic       t_en = 1'b0, t_adc = 1'b0, t_vi = 1'b0, t_vq = 1'b0;
  logic [4:0] t_i = 5'd0, t_q = 5'd0;
  int         n_assert = 0;
  int         n_fail = 0;

  iq_demod_ctrl_if #(.CNT_W(16)) bus ();
  iq_demod_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus.enable   = t_en;   assign bus4.enable   = t_en;
  assign bus.ADC_rdy  = t_adc;  assign bus4.ADC_rdy  = t_adc;
  assign bus.valid_I  = t_vi;   assign bus4.valid_I  = t_vi;
  assign bus.valid_Q  = t_vq;   assign bus4.valid_Q  = t_vq;
  assign bus.I_filt   = t_i;    assign bus4.I_filt   = t_i;
  assign bus.Q_filt   = t_q;    assign bus4.Q_filt   = t_q;

  iq_demod_ctrl #(.SETTLE_SAMPLES(20), .TIMEOUT(256), .CNT_W(16)) dut (
    .clk(clk), .resetn(t_resetn), .bus(bus)
  );
  iq_demod_ctrl #(.SETTLE_SAMPLES(20), .TIMEOUT(256), .CNT_W(4)) dut4 (
    .clk(clk), .resetn(t_resetn), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One ADC strobe, coincident filter output two cycles later, one quiet cycle.
  task automatic sample(input logic [4:0] i, input logic [4:0] q,
                        input logic [2:0] exp_st, input logic exp_v);
    t_adc = 1'b1;
    #1;
    check("demod_en_strobe", 32'(bus.demod_en), 32'd1);
    tick();
    t_adc = 1'b0;
    tick();
    t_vi = 1'b1; t_vq = 1'b1; t_i = i; t_q = q;
    tick();
    check("state_after_cv", 32'(bus.state), 32'(exp_st));
    check("valid_after_cv", 32'(bus.demod_iq_valid), 32'(exp_v));
    t_vi = 1'b0; t_vq = 1'b0;
    tick();
  endtask

  task automatic settle_all();
    for (int k = 1; k <= 20; k++) begin
      sample(5'd1, 5'd1, (k < 20) ? 3'd2 : 3'd3, 1'b0);
    end
  endtask

  initial begin
    // Reset
    t_adc = 1'b1;
    tick(); tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_flush", 32'(bus.filt_flush), 32'd0);
    check("rst_valid", 32'(bus.demod_iq_valid), 32'd0);
    check("rst_cnt", 32'(bus.sample_cnt), 32'd0);
    check("rst_ibb", 32'($unsigned(bus.I_BB)), 32'd0);
    check("rst_demod_en", 32'(bus.demod_en), 32'd0);

    // Bring-up
    t_resetn = 1'b0; t_adc = 1'b0; t_en = 1'b1;
    tick();
    check("flush_state", 32'(bus.state), 32'd1);
    check("flush_pulse", 32'(bus.filt_flush), 32'd1);
    check("lo_rst_pulse", 32'(bus.lo_phase_rst), 32'd1);
    tick();
    check("settle_state", 32'(bus.state), 32'd2);
    check("flush_single", 32'(bus.filt_flush), 32'd0);
    check("lo_rst_single", 32'(bus.lo_phase_rst), 32'd0);
    settle_all();
    sample(5'b00111, 5'b11101, 3'd3, 1'b1);
    check("first_ibb", 32'($unsigned(bus.I_BB)), 32'd7);
    check("first_qbb", 32'($unsigned(bus.Q_BB)), 32'b11101);
    check("valid_one_cycle", 32'(bus.demod_iq_valid), 32'd0);
    check("cnt_one", 32'(bus.sample_cnt), 32'd1);

    // Counter saturation: 19 further deliveries, 20 in total
    for (int d = 2; d <= 20; d++) begin
      sample(5'(d), 5'(-d), 3'd3, 1'b1);
    end
    check("last_ibb", 32'($unsigned(bus.I_BB)), 32'b10100);
    check("last_qbb", 32'($unsigned(bus.Q_BB)), 32'b01100);
    check("cnt_twenty", 32'(bus.sample_cnt), 32'd20);
    check("cnt4_saturated", 32'(bus4.sample_cnt), 32'd15);

    // Watchdog: 255 idle cycles then a strobe keeps RUN
    t_adc = 1'b1; tick();
    t_adc = 1'b0;
    repeat (255) tick();
    check("wd255_state", 32'(bus.state), 32'd3);
    t_adc = 1'b1; tick();
    check("wd_cleared_state", 32'(bus.state), 32'd3);
    check("wd_cleared_flag", 32'(bus.starve_err), 32'd0);

    // Starvation: 256 idle cycles
    t_adc = 1'b0;
    repeat (255) tick();
    check("starve_pre", 32'(bus.state), 32'd3);
    tick();
    check("starve_state", 32'(bus.state), 32'd4);
    check("starve_flag", 32'(bus.starve_err), 32'd1);
    check("starve_sync_clear", 32'(bus.sync_err), 32'd0);
    t_adc = 1'b1; #1;
    check("starve_demod_en", 32'(bus.demod_en), 32'd0);
    t_adc = 1'b0;

    // Recovery
    t_en = 1'b0; tick();
    check("rec_idle", 32'(bus.state), 32'd0);
    check("rec_flag_sticky", 32'(bus.starve_err), 32'd1);
    t_en = 1'b1; tick();
    check("rec_flush", 32'(bus.state), 32'd1);
    check("rec_flush_pulse", 32'(bus.filt_flush), 32'd1);
    tick();
    check("rec_settle", 32'(bus.state), 32'd2);
    check("rec_starve_clr", 32'(bus.starve_err), 32'd0);
    check("rec_cnt_clr", 32'(bus.sample_cnt), 32'd0);

    // Desync in RUN
    settle_all();
    t_vi = 1'b1; t_vq = 1'b0; t_i = 5'd9; t_q = 5'd9;
    tick();
    check("desync_state", 32'(bus.state), 32'd4);
    check("desync_flag", 32'(bus.sync_err), 32'd1);
    check("desync_no_valid", 32'(bus.demod_iq_valid), 32'd0);
    check("desync_cnt", 32'(bus.sample_cnt), 32'd0);
    t_vi = 1'b0; t_adc = 1'b1; #1;
    check("desync_demod_en", 32'(bus.demod_en), 32'd0);
    tick();
    check("desync_hold", 32'(bus.state), 32'd4);
    t_adc = 1'b0;

    // Mid-run abort with enable=0 coincident with cv
    t_en = 1'b0; tick();
    check("abort_idle_sync_sticky", 32'(bus.sync_err), 32'd1);
    t_en = 1'b1; tick();
    check("abort_sync_clr", 32'(bus.sync_err), 32'd0);
    tick();
    settle_all();
    sample(5'd3, 5'd4, 3'd3, 1'b1);
    check("abort_cnt_pre", 32'(bus.sample_cnt), 32'd1);
    t_vi = 1'b1; t_vq = 1'b1; t_i = 5'd11; t_q = 5'd12; t_en = 1'b0;
    tick();
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_no_valid", 32'(bus.demod_iq_valid), 32'd0);
    check("abort_ibb_hold", 32'($unsigned(bus.I_BB)), 32'd3);
    t_vi = 1'b0; t_vq = 1'b0;

    // Reset asserted in SETTLE
    t_en = 1'b1; tick(); tick();
    check("rs_settle", 32'(bus.state), 32'd2);
    for (int k = 0; k < 3; k++) begin
      sample(5'd2, 5'd2, 3'd2, 1'b0);
    end
    t_resetn = 1'b1; t_adc = 1'b1;
    tick();
    check("rs_state", 32'(bus.state), 32'd0);
    check("rs_flush", 32'(bus.filt_flush), 32'd0);
    check("rs_lo", 32'(bus.lo_phase_rst), 32'd0);
    check("rs_valid", 32'(bus.demod_iq_valid), 32'd0);
    check("rs_ibb", 32'($unsigned(bus.I_BB)), 32'd0);
    check("rs_qbb", 32'($unsigned(bus.Q_BB)), 32'd0);
    check("rs_cnt", 32'(bus.sample_cnt), 32'd0);
    check("rs_demod_en", 32'(bus.demod_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_demod_ctrl.md
# iq_demod_ctrl

Sequencing controller for the IQ demodulation chain (mixer, twin 20-tap I/Q filters, LO sine/cosine generator). It brings the chain up from a clean state, gates ADC samples into the mixer, discards filter-settling samples, and aligns the I/Q filter outputs into a single registered valid/data stream for the CORDIC. It also watches for I/Q valid desynchronisation and ADC starvation, and reports both through sticky error flags.

## Interface
- SETTLE_SAMPLES, 20: number of coincident filter outputs discarded after start (filter fill).
- TIMEOUT, 256: clock cycles without `ADC_rdy` in RUN before a starvation error is raised.
- CNT_W, 16: width of `sample_cnt`.
- clk  in  1  single system clock; all logic is on the rising edge.
- resetn  in  1  reset, synchronous and active-high (`resetn`=1 resets on the next edge).
- enable  in  1  level; 1 requests that the chain run, 0 requests return to IDLE.
- ADC_rdy  in  1  ADC sample strobe.
- valid_I  in  1  out_valid of the I filter.
- valid_Q  in  1  out_valid of the Q filter.
- I_filt  in  5  signed I filter output.
- Q_filt  in  5  signed Q filter output.
- demod_en  out  1  gated sample strobe to the mixer (its `ADC_rdy`).
- filt_flush  out  1  one-cycle clear pulse to both filters.
- lo_phase_rst  out  1  one-cycle phase reset to the LO generator.
- demod_iq_valid  out  1  registered output valid to the CORDIC.
- I_BB  out  5  registered signed I to the CORDIC.
- Q_BB  out  5  registered signed Q to the CORDIC.
- state  out  3  encoding: IDLE=0, FLUSH=1, SETTLE=2, RUN=3, ERROR=4.
- sync_err  out  1  sticky flag: `valid_I` ≠ `valid_Q` was detected.
- starve_err  out  1  sticky flag: ADC timeout.
- sample_cnt  out  CNT_W  number of samples delivered since the last FLUSH; saturates.

## Operation
- Coincident valid: `cv = valid_I & valid_Q`.
- IDLE:
  - `demod_en`=0.
  - `enable`=1 → FLUSH.
- FLUSH:
  - Lasts exactly 1 cycle.
  - `filt_flush`=1 and `lo_phase_rst`=1.
  - Clears the settle counter, watchdog, `sample_cnt`, `sync_err` and `starve_err`.
  - → SETTLE.
- SETTLE:
  - `demod_en = ADC_rdy`.
  - Each `cv` increments the settle counter. These samples are not delivered.
  - When the counter reaches SETTLE_SAMPLES → RUN. The SETTLE_SAMPLES-th `cv` is itself discarded.
- RUN:
  - `demod_en = ADC_rdy`.
  - On `cv`, capture `I_filt`/`Q_filt` into `I_BB`/`Q_BB` and set `demod_iq_valid`=1 for one cycle.
  - `sample_cnt` increments per delivered sample and saturates at 2^CNT_W−1.
  - Watchdog counts cycles with `ADC_rdy`=0 and clears on `ADC_rdy`=1. Reaching TIMEOUT sets `starve_err` → ERROR.
- Sync check:
  - Applies in SETTLE and RUN.
  - Any cycle with `valid_I` ≠ `valid_Q` sets `sync_err` → ERROR.
  - That cycle delivers nothing.
- ERROR:
  - `demod_en`=0 and `demod_iq_valid`=0.
  - Holds until `enable`=0, then → IDLE.
  - The flags stay set until the next FLUSH or reset.
- `enable`=0 in FLUSH, SETTLE or RUN → IDLE next cycle. Any in-flight sample is dropped.
- Priority within a cycle:
  1. reset
  2. `enable`=0
  3. error detection
  4. normal transition
- `I_BB`/`Q_BB` hold their last value when `demod_iq_valid`=0.
- The watchdog saturates. The settle counter must be wide enough for SETTLE_SAMPLES.

## Timing
- Reset values:
  - state=IDLE.
  - `demod_en`, `filt_flush`, `lo_phase_rst`, `demod_iq_valid`, `sync_err`, `starve_err` = 0.
  - `I_BB`=`Q_BB`=0.
  - `sample_cnt`=0.
- Reset mid-operation returns to IDLE on the next edge, with no flush pulse.
- `demod_en` is combinational from `ADC_rdy` and the registered state: zero latency.
- `filt_flush` and `lo_phase_rst` are registered decodes of state FLUSH. They are high in the cycle after the IDLE→FLUSH edge.
- Output latency: `cv` at cycle N in RUN gives `demod_iq_valid`, `I_BB` and `Q_BB` at cycle N+1 (one register stage).
- The error transition is registered: the mismatch at cycle N gives state=ERROR and the sticky flag set at N+1.
- `state` output is the registered state.

## Test plan
- Bring-up:
  - Stimulus: reset, `enable`=1, ADC_rdy every 4 cycles, filters return `cv` 2 cycles after each strobe.
  - Required: exactly one FLUSH cycle with both pulses; the first 20 `cv` are dropped; the 21st is delivered one cycle later with matching `I_BB`/`Q_BB` (e.g. 5'sd7/−5'sd3).
- Desync:
  - Stimulus: in RUN, `valid_I`=1, `valid_Q`=0 for one cycle.
  - Required: no output; `sync_err`=1 and state=4 next cycle; `demod_en`=0 thereafter.
- Starvation:
  - Stimulus: in RUN, hold `ADC_rdy`=0 for 256 cycles.
  - Required: `starve_err`=1 and ERROR. With 255 idle cycles then a strobe: stays in RUN.
- Recovery:
  - Stimulus: from ERROR, `enable`=0 for 1 cycle, then `enable`=1.
  - Required: IDLE → FLUSH → SETTLE; flags cleared; `sample_cnt`=0.
- Mid-run abort:
  - Stimulus: `enable`=0 in the same cycle as a `cv`.
  - Required: no `demod_iq_valid`; IDLE next cycle.
  - Stimulus: reset asserted in SETTLE.
  - Required: all outputs at reset values next cycle.
- Counter saturation:
  - Stimulus: CNT_W=4, deliver 20 samples.
  - Required: `sample_cnt` stops at 15.
